// File: rtl/power_telemetry_sampler.sv
// Windowed power/TOPS telemetry reducer feeding a first-word-fall-through record FIFO.
// Optional energy accumulator is built only when TELEM_ENERGY_ACC_EN is defined.
module power_telemetry_sampler #(
  parameter int FIFO_DEPTH   = 8,
  parameter int DEF_WIN_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  win_log2_cfg,
  input  logic [15:0] current_power_mw,
  input  logic [15:0] current_tops,
  input  logic [15:0] power_budget,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] sample_power_avg_mw,
  output logic [15:0] sample_tops_avg,
  output logic [15:0] sample_peak_mw,
  output logic        sample_over_budget,
  output logic [15:0] sample_seq,
  output logic [6:0]  fifo_count,
  output logic [15:0] overflow_count,
  input  logic        energy_clr,
  output logic [47:0] energy_mw_cycles
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [15:0] pwr;
    logic [15:0] tops;
    logic [15:0] peak;
    logic        ob;
    logic [15:0] seq;
  } rec_t;

  state_t             state_q, state_d;
  logic [3:0]         win_log2_q, win_log2_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        psum_q, psum_d, tsum_q, tsum_d;
  logic [15:0]        peak_q, peak_d;
  logic [15:0]        seq_q, seq_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]         count_q, count_d;
  logic [15:0]        ovf_q, ovf_d;

  logic [3:0]  cfg_log2;
  logic [31:0] psum_sample, tsum_sample;
  logic [15:0] peak_sample, win_last, avg_pwr;
  logic        push, push_acc, pop, full;
  rec_t        new_rec, head;
  rec_t        mem [FIFO_DEPTH];

  always_comb begin
    cfg_log2    = (win_log2_cfg == 4'd0) ? 4'(DEF_WIN_LOG2) : win_log2_cfg;
    psum_sample = psum_q + {16'd0, current_power_mw};
    tsum_sample = tsum_q + {16'd0, current_tops};
    peak_sample = (current_power_mw > peak_q) ? current_power_mw : peak_q;
    win_last    = (16'd1 << win_log2_q) - 16'd1;
    avg_pwr     = 16'(psum_sample >> win_log2_q);

    new_rec.pwr  = avg_pwr;
    new_rec.tops = 16'(tsum_sample >> win_log2_q);
    new_rec.peak = peak_sample;
    new_rec.ob   = avg_pwr > power_budget;
    new_rec.seq  = seq_q;

    state_d    = state_q;
    win_log2_d = win_log2_q;
    cnt_d      = cnt_q;
    psum_d     = psum_q;
    tsum_d     = tsum_q;
    peak_d     = peak_q;
    seq_d      = seq_q;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = ACCUM;
          win_log2_d = cfg_log2;
          cnt_d      = '0;
          psum_d     = '0;
          tsum_d     = '0;
          peak_d     = '0;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == win_last) begin
          // Window closes with this cycle's sample; next window starts immediately.
          push       = 1'b1;
          seq_d      = seq_q + 16'd1;
          win_log2_d = cfg_log2;
          cnt_d      = '0;
          psum_d     = '0;
          tsum_d     = '0;
          peak_d     = '0;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          psum_d = psum_sample;
          tsum_d = tsum_sample;
          peak_d = peak_sample;
        end
      end
      default: state_d = IDLE;
    endcase

    pop      = (count_q != 7'd0) && sample_ready;
    full     = count_q == 7'(FIFO_DEPTH);
    push_acc = push && (!full || pop);
    count_d  = count_q + 7'(push_acc) - 7'(pop);
    wr_ptr_d = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    ovf_d    = ovf_q;
    if (push && !push_acc && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      win_log2_q <= '0;
      cnt_q      <= '0;
      psum_q     <= '0;
      tsum_q     <= '0;
      peak_q     <= '0;
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      win_log2_q <= win_log2_d;
      cnt_q      <= cnt_d;
      psum_q     <= psum_d;
      tsum_q     <= tsum_d;
      peak_q     <= peak_d;
      seq_q      <= seq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= new_rec;
  end

  // Record outputs are gated by valid so reset forces them to zero without clearing storage.
  assign head                = mem[rd_ptr_q];
  assign sample_valid        = count_q != 7'd0;
  assign sample_power_avg_mw = sample_valid ? head.pwr  : 16'd0;
  assign sample_tops_avg     = sample_valid ? head.tops : 16'd0;
  assign sample_peak_mw      = sample_valid ? head.peak : 16'd0;
  assign sample_over_budget  = sample_valid ? head.ob   : 1'b0;
  assign sample_seq          = sample_valid ? head.seq  : 16'd0;
  assign fifo_count          = count_q;
  assign overflow_count      = ovf_q;

`ifdef TELEM_ENERGY_ACC_EN
  logic [47:0] energy_q, energy_d;
  logic [48:0] energy_sum;

  always_comb begin
    energy_sum = {1'b0, energy_q} + {33'd0, current_power_mw};
    energy_d   = energy_q;
    if (energy_clr)  energy_d = '0;
    else if (enable) energy_d = energy_sum[48] ? {48{1'b1}} : energy_sum[47:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) energy_q <= '0;
    else       energy_q <= energy_d;
  end

  assign energy_mw_cycles = energy_q;
`else
  logic unused_energy_clr;
  assign unused_energy_clr = energy_clr;
  assign energy_mw_cycles  = '0;
`endif

endmodule

// File: tb/tb_power_telemetry_sampler.sv
// Bench for power_telemetry_sampler: window/queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_power_telemetry_sampler;
  localparam int DEPTH = 8;
  localparam int DEF_L = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  win_log2_cfg;
  logic [15:0] current_power_mw;
  logic [15:0] current_tops;
  logic [15:0] power_budget;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_power_avg_mw;
  logic [15:0] sample_tops_avg;
  logic [15:0] sample_peak_mw;
  logic        sample_over_budget;
  logic [15:0] sample_seq;
  logic [6:0]  fifo_count;
  logic [15:0] overflow_count;
  logic        energy_clr;
  logic [47:0] energy_mw_cycles;

  power_telemetry_sampler #(.FIFO_DEPTH(DEPTH), .DEF_WIN_LOG2(DEF_L)) dut (
    .clk(clk), .reset(reset), .enable(enable), .win_log2_cfg(win_log2_cfg),
    .current_power_mw(current_power_mw), .current_tops(current_tops),
    .power_budget(power_budget), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_power_avg_mw(sample_power_avg_mw), .sample_tops_avg(sample_tops_avg),
    .sample_peak_mw(sample_peak_mw), .sample_over_budget(sample_over_budget),
    .sample_seq(sample_seq), .fifo_count(fifo_count), .overflow_count(overflow_count),
    .energy_clr(energy_clr), .energy_mw_cycles(energy_mw_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window is a list of samples; a record appears when the list holds 2^L entries.
  typedef struct {
    int pwr;
    int tops;
    int peak;
    int ob;
    int seq;
  } rec_t;

  rec_t   m_fifo[$];
  int     m_pw[$];
  int     m_tp[$];
  bit     m_active = 0;
  int     m_L = 0;
  int     m_seq = 0;
  int     m_ovf = 0;
  longint m_energy = 0;

  function automatic int cfg_to_l(input int cfg);
    return (cfg == 0) ? DEF_L : cfg;
  endfunction

  task automatic model_step();
    bit   pop  = (m_fifo.size() > 0) && sample_ready;
    bit   full = (m_fifo.size() == DEPTH);
    bit   have = 0;
    rec_t r;
`ifdef TELEM_ENERGY_ACC_EN
    if (energy_clr) m_energy = 0;
    else if (enable) begin
      m_energy = m_energy + longint'(current_power_mw);
      if (m_energy > 64'hFFFF_FFFF_FFFF) m_energy = 64'hFFFF_FFFF_FFFF;
    end
`endif
    if (!m_active) begin
      if (enable) begin
        m_active = 1;
        m_L = cfg_to_l(int'(win_log2_cfg));
        m_pw.delete();
        m_tp.delete();
      end
    end else if (!enable) begin
      m_active = 0;
    end else begin
      m_pw.push_back(int'(current_power_mw));
      m_tp.push_back(int'(current_tops));
      if (m_pw.size() == (1 << m_L)) begin
        longint sp = 0;
        longint st = 0;
        int pk = 0;
        foreach (m_pw[i]) begin
          sp += m_pw[i];
          st += m_tp[i];
          if (m_pw[i] > pk) pk = m_pw[i];
        end
        r.pwr  = int'(sp / (longint'(1) << m_L));
        r.tops = int'(st / (longint'(1) << m_L));
        r.peak = pk;
        r.ob   = (r.pwr > int'(power_budget)) ? 1 : 0;
        r.seq  = m_seq;
        m_seq  = (m_seq + 1) % 65536;
        have   = 1;
        m_pw.delete();
        m_tp.delete();
        m_L = cfg_to_l(int'(win_log2_cfg));
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (have) begin
      if (!full || pop) m_fifo.push_back(r);
      else if (m_ovf < 65535) m_ovf++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_fifo.delete();
        m_pw.delete();
        m_tp.delete();
        m_active = 0;
        m_seq = 0;
        m_ovf = 0;
        m_energy = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on && !reset) begin
        chk("valid", sample_valid, (m_fifo.size() != 0) ? 1 : 0);
        chk("fifo_count", fifo_count, m_fifo.size());
        chk("overflow_count", overflow_count, m_ovf);
        chk("energy", energy_mw_cycles, m_energy);
        if (m_fifo.size() != 0) begin
          chk("head_avg", sample_power_avg_mw, m_fifo[0].pwr);
          chk("head_tops", sample_tops_avg, m_fifo[0].tops);
          chk("head_peak", sample_peak_mw, m_fifo[0].peak);
          chk("head_ob", sample_over_budget, m_fifo[0].ob);
          chk("head_seq", sample_seq, m_fifo[0].seq);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    win_log2_cfg = 4'd3;
    current_power_mw = '0;
    current_tops = '0;
    power_budget = '0;
    sample_ready = 1'b0;
    energy_clr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!sample_valid && n < max);
    chk("wait_valid", sample_valid, 1);
  endtask

  int n;

  initial begin
    do_reset();
    cmp_on = 1'b1;
    chk("rst_valid", sample_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow_count, 0);
    chk("rst_seq", sample_seq, 0);
    chk("rst_energy", energy_mw_cycles, 0);

    // Constant stimulus, L=3
    win_log2_cfg = 4'd3; current_power_mw = 16'd500; current_tops = 16'd1000;
    power_budget = 16'd8000; sample_ready = 1'b1; enable = 1'b1;
    wait_valid(20, n);
    chk("const_latency", n, 9);
    chk("const_avg", sample_power_avg_mw, 500);
    chk("const_tops", sample_tops_avg, 1000);
    chk("const_peak", sample_peak_mw, 500);
    chk("const_ob", sample_over_budget, 0);
    chk("const_seq0", sample_seq, 0);
    wait_valid(20, n);
    chk("const_period", n, 8);
    chk("const_seq1", sample_seq, 1);
    wait_valid(20, n);
    chk("const_seq2", sample_seq, 2);
    enable = 1'b0;
    tick(2);

    // Ramp 100..800 with budgets 400 then 450
    for (int b = 0; b < 2; b++) begin
      do_reset();
      win_log2_cfg = 4'd3; current_tops = 16'd2000;
      power_budget = (b == 0) ? 16'd400 : 16'd450;
      enable = 1'b1;
      tick(1);
      for (int i = 1; i <= 8; i++) begin
        current_power_mw = 16'(100 * i);
        tick(1);
      end
      enable = 1'b0;
      chk("ramp_valid", sample_valid, 1);
      chk("ramp_avg", sample_power_avg_mw, 450);
      chk("ramp_peak", sample_peak_mw, 800);
      chk("ramp_tops", sample_tops_avg, 2000);
      chk("ramp_ob", sample_over_budget, (b == 0) ? 1 : 0);
      tick(2);
    end

    // Overflow: L=1, ready held low for 10 windows
    do_reset();
    win_log2_cfg = 4'd1; current_power_mw = 16'd300; current_tops = 16'd10;
    enable = 1'b1;
    tick(21);
    enable = 1'b0;
    chk("ovf_count", fifo_count, 8);
    chk("ovf_dropped", overflow_count, 2);
    sample_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_seq", sample_seq, i);
      tick(1);
    end
    chk("ovf_empty", fifo_count, 0);
    enable = 1'b1;
    wait_valid(10, n);
    chk("ovf_gap_seq", sample_seq, 10);
    enable = 1'b0;
    tick(2);

    // Enable abort, then async reset with a record queued
    do_reset();
    win_log2_cfg = 4'd3; current_power_mw = 16'd200; current_tops = 16'd50;
    sample_ready = 1'b1; enable = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(5);
    chk("abort_no_rec", sample_valid, 0);
    enable = 1'b1;
    wait_valid(20, n);
    chk("abort_latency", n, 9);
    chk("abort_seq", sample_seq, 0);
    sample_ready = 1'b0;
    tick(4);
    chk("pre_rst_count", fifo_count, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_valid", sample_valid, 0);
    chk("async_count", fifo_count, 0);
    chk("async_avg", sample_power_avg_mw, 0);
    chk("async_tops", sample_tops_avg, 0);
    chk("async_peak", sample_peak_mw, 0);
    chk("async_seq", sample_seq, 0);
    chk("async_ovf", overflow_count, 0);
    chk("async_energy", energy_mw_cycles, 0);
    tick(1);
    reset = 1'b0;
    enable = 1'b0;

    // Full FIFO with push+pop on window end; cfg 3->2 mid-window
    do_reset();
    win_log2_cfg = 4'd3; current_power_mw = 16'd800; power_budget = 16'hFFFF;
    enable = 1'b1;
    tick(65);
    chk("full_count", fifo_count, 8);
    current_power_mw = 16'd100;
    tick(2);
    win_log2_cfg = 4'd2;
    tick(2);
    current_power_mw = 16'd900;
    tick(3);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    chk("pp_count", fifo_count, 8);
    chk("pp_ovf", overflow_count, 0);
    chk("pp_head_seq", sample_seq, 1);
    tick(3);
    chk("short_win_pending", overflow_count, 0);
    tick(1);
    chk("short_win_drop", overflow_count, 1);
    enable = 1'b0;
    sample_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("pp_drain_seq", sample_seq, i);
      if (i == 8) begin
        chk("pp_long_avg", sample_power_avg_mw, 500);
        chk("pp_long_peak", sample_peak_mw, 900);
      end
      tick(1);
    end

    // Energy accumulator
    do_reset();
    sample_ready = 1'b1; current_power_mw = 16'd1000; enable = 1'b1;
    tick(100);
`ifdef TELEM_ENERGY_ACC_EN
    chk("energy_100", energy_mw_cycles, 100000);
`else
    chk("energy_off", energy_mw_cycles, 0);
`endif
    energy_clr = 1'b1;
    tick(1);
    chk("energy_clr", energy_mw_cycles, 0);
    energy_clr = 1'b0;
    tick(1);
`ifdef TELEM_ENERGY_ACC_EN
    chk("energy_after_clr", energy_mw_cycles, 1000);
`else
    chk("energy_off2", energy_mw_cycles, 0);
`endif
    enable = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/power_telemetry_sampler.md
Name: power_telemetry_sampler

Overview:
Sits directly downstream of advanced_power_manager. Consumes its per-cycle current_power_mw / current_tops estimates and reduces them to fixed-length windowed records: average power, average TOPS, peak power, an over-budget flag and a sequence number. Records are queued in a small FWFT FIFO with a valid/ready drain port. Sweep benches and the host telemetry path read this port instead of sampling raw signals at ad-hoc times.

Parameters:
FIFO_DEPTH, 8, record FIFO depth; power of two, 2..64
DEF_WIN_LOG2, 6, window length log2 used when win_log2_cfg==0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  sampling enable
win_log2_cfg  in  4  window = 2^win_log2_cfg cycles; 0 selects DEF_WIN_LOG2
current_power_mw  in  16  instantaneous power from power manager
current_tops  in  16  instantaneous throughput (milli-TOPS) from power manager
power_budget  in  16  budget in mW for over-budget compare
sample_valid  out  1  FIFO head record valid
sample_ready  in  1  consumer accepts head record
sample_power_avg_mw  out  16  head record: window average power
sample_tops_avg  out  16  head record: window average TOPS
sample_peak_mw  out  16  head record: window max power
sample_over_budget  out  1  head record: avg power > budget
sample_seq  out  16  head record: window sequence number
fifo_count  out  7  records queued
overflow_count  out  16  records dropped on full FIFO, saturating
energy_clr  in  1  clears energy accumulator (feature only)
energy_mw_cycles  out  48  energy accumulator (feature only)

Behaviour:
- Reset (async): state IDLE; FIFO empty; sample_valid=0; every record output, fifo_count, overflow_count, sample_seq counter and energy_mw_cycles = 0.
- States: IDLE, ACCUM.
- IDLE -> ACCUM: taken when enable=1. On entry:
  - latch window log2 (L) from win_log2_cfg, or DEF_WIN_LOG2 when the cfg is 0;
  - clear cycle counter, 32-bit sum registers and peak.
- ACCUM, every cycle: add current_power_mw and current_tops to their sums; peak = max(peak, power); increment cycle counter.
- Window end: the cycle the counter reaches 2^L-1. In that cycle the record is formed from the sums including that cycle's sample:
  - avg = sum >> L, truncated;
  - over_budget = (avg_power > power_budget sampled in that cycle); equality gives 0;
  - seq = current sequence counter.
- At the window-end edge:
  - the record is written to the FIFO;
  - the sequence counter increments, wrapping at 0xFFFF->0;
  - a new window starts with zero gap, re-latching L from cfg.
  - cfg changes mid-window take effect only at the next window boundary.
- enable=0 in ACCUM: go to IDLE the next edge. The partial window is discarded with no record; seq is not incremented. FIFO contents are retained and remain drainable.
- FIFO is first-word-fall-through:
  - sample_valid = (fifo_count != 0);
  - head record fields are stable while sample_valid=1 and sample_ready=0;
  - pop occurs on sample_valid & sample_ready;
  - pointers wrap modulo FIFO_DEPTH.
- Push while full:
  - with a same-cycle pop: push accepted, count unchanged;
  - without a pop: record dropped and overflow_count increments, saturating at 0xFFFF. seq still increments, so drops appear as sequence gaps.
- Push into an empty FIFO: visible at the output the next cycle (1-cycle latency).
- Inputs are sampled on every edge; there is no input handshake.

Optional Feature:
TELEM_ENERGY_ACC_EN.
- Defined:
  - energy_mw_cycles adds current_power_mw every cycle enable=1 (in IDLE or ACCUM), saturating at 2^48-1;
  - energy_clr=1 zeroes it, and clear has priority over the same-cycle add.
- Undefined: energy_mw_cycles is driven constant 0, energy_clr is ignored, and no accumulator flops are inferred.

Test Plan:
- Constant stimulus: L=3, power=500, tops=1000, budget=8000, enable held, ready=1. Expected: first record 9 cycles after enable (8 accumulate cycles + 1 push cycle) with avg 500 / tops 1000 / peak 500 / over_budget 0 / seq 0; then one record every 8 cycles, seq 1,2,...
- Ramp with budget compare: L=3, power ramps 100..800 step 100 within one window, budget=400. Expected record avg 450, peak 800, over_budget 1. Repeat with budget=450 -> over_budget 0.
- FIFO overflow: FIFO_DEPTH=8, L=1, ready=0 for 10 windows. Expected fifo_count=8, overflow_count=2, FIFO holds seq 0..7. Then ready=1: drains 0..7 in order, and the next record pushed carries seq 10.
- Enable abort and reset:
  - enable drops after 5 cycles of an L=3 window -> no record, seq unchanged; re-enable -> fresh full window, seq continues.
  - Assert reset mid-window with records queued -> all outputs 0 immediately, without waiting for a clock edge.
- Full FIFO with simultaneous push/pop: FIFO full, ready=1 exactly on a window-end cycle. Expected push accepted, fifo_count stays 8, overflow_count unchanged. Also change win_log2_cfg 3->2 mid-window: the current record still averages over 8 cycles, and the next window is 4 cycles.
- Energy accumulator (TELEM_ENERGY_ACC_EN defined):
  - power=1000 for 100 enabled cycles -> energy_mw_cycles=100000;
  - energy_clr pulse -> 0 the next cycle;
  - preload near saturation via long run at 0xFFFF -> holds at 2^48-1.
  - With the macro undefined -> output remains 0 throughout.
